// File: rtl/i2c_master.sv
// rtl/i2c_master.sv - byte-oriented open-drain I2C bus master with command/ready handshake
module i2c_master (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [15:0] dvsr_i,
  input  logic [7:0]  din_i,
  input  logic [2:0]  cmd_i,
  input  logic        wr_i2c_i,
  inout  wire         scl_io,
  inout  wire         sda_io,
  output logic        ready_o,
  output logic        done_tick_o,
  output logic        ack_o,
  output logic [7:0]  dout_o
);

  localparam logic [2:0] CMD_START   = 3'b000;
  localparam logic [2:0] CMD_WR      = 3'b001;
  localparam logic [2:0] CMD_RD      = 3'b010;
  localparam logic [2:0] CMD_STOP    = 3'b011;
  localparam logic [2:0] CMD_RESTART = 3'b100;

  typedef enum logic [3:0] {
    S_IDLE, S_START1, S_START2, S_HOLD, S_DATA1, S_DATA2, S_DATA3,
    S_DATA4, S_DATA_END, S_RESTART, S_STOP1, S_STOP2
  } state_t;

  state_t      state, state_n;
  logic [16:0] c, c_n;
  logic [15:0] q_len, q_n, qtr_now;
  logic [3:0]  bit_cnt, bit_n;
  logic [8:0]  tx, tx_n, rx, rx_n;
  logic        done_n, ack_n;
  logic [7:0]  dout_n;
  logic        scl_q, sda_q, scl_n, sda_n;
  logic        sda_in, q_end, h_end;

  // Pads are only ever pulled low or released; the SDA level seen includes the slave
  assign scl_io = scl_q ? 1'bz : 1'b0;
  assign sda_io = sda_q ? 1'bz : 1'b0;
  assign sda_in = sda_io;

  // A divisor of 0 would never end a phase, so it behaves as 1
  assign qtr_now = (dvsr_i == 16'd0) ? 16'd1 : dvsr_i;
  assign q_end   = (c == {1'b0, q_len} - 17'd1);
  assign h_end   = (c == {q_len, 1'b0} - 17'd1);

  // State register plus all datapath registers; pads release immediately on reset
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= S_IDLE;
      c           <= '0;
      q_len       <= 16'd1;
      bit_cnt     <= '0;
      tx          <= '1;
      rx          <= '0;
      done_tick_o <= 1'b0;
      ack_o       <= 1'b0;
      dout_o      <= '0;
      scl_q       <= 1'b1;
      sda_q       <= 1'b1;
    end else begin
      state       <= state_n;
      c           <= c_n;
      q_len       <= q_n;
      bit_cnt     <= bit_n;
      tx          <= tx_n;
      rx          <= rx_n;
      done_tick_o <= done_n;
      ack_o       <= ack_n;
      dout_o      <= dout_n;
      scl_q       <= scl_n;
      sda_q       <= sda_n;
    end
  end

  // Next-state and datapath update: phase timing, bit shifting, command decode
  always_comb begin
    state_n = state;
    c_n     = c + 17'd1;
    q_n     = q_len;
    bit_n   = bit_cnt;
    tx_n    = tx;
    rx_n    = rx;
    done_n  = 1'b0;
    ack_n   = ack_o;
    dout_n  = dout_o;
    case (state)
      S_IDLE: begin
        if (wr_i2c_i && cmd_i == CMD_START) state_n = S_START1;
      end
      S_START1:   if (h_end) state_n = S_START2;
      S_START2:   if (q_end) state_n = S_HOLD;
      S_HOLD: begin
        if (wr_i2c_i) begin
          case (cmd_i)
            CMD_WR: begin
              tx_n    = {din_i, 1'b1};
              bit_n   = 4'd0;
              state_n = S_DATA1;
            end
            CMD_RD: begin
              tx_n    = {8'hFF, din_i[0]};
              bit_n   = 4'd0;
              state_n = S_DATA1;
            end
            CMD_STOP:                state_n = S_STOP1;
            CMD_START, CMD_RESTART:  state_n = S_RESTART;
            default:                 state_n = S_HOLD;
          endcase
        end
      end
      S_DATA1:    if (q_end) state_n = S_DATA2;
      S_DATA2: begin
        if (q_end) begin
          rx_n    = {rx[7:0], sda_in};
          state_n = S_DATA3;
        end
      end
      S_DATA3:    if (q_end) state_n = S_DATA4;
      S_DATA4: begin
        if (q_end) begin
          if (bit_cnt == 4'd8) begin
            done_n  = 1'b1;
            dout_n  = rx[8:1];
            ack_n   = rx[0];
            state_n = S_DATA_END;
          end else begin
            tx_n    = {tx[7:0], 1'b0};
            bit_n   = bit_cnt + 4'd1;
            state_n = S_DATA1;
          end
        end
      end
      S_DATA_END: if (q_end) state_n = S_HOLD;
      S_RESTART:  if (h_end) state_n = S_START1;
      S_STOP1:    if (h_end) state_n = S_STOP2;
      S_STOP2:    if (h_end) state_n = S_IDLE;
      default:    state_n = S_IDLE;
    endcase
    if (state == S_IDLE || state == S_HOLD) c_n = '0;
    // Every phase restarts the count and picks up the divisor current at that moment
    if (state_n != state) begin
      c_n = '0;
      q_n = qtr_now;
    end
  end

  // Line levels are decoded from the upcoming state so the pad registers are glitch-free
  always_comb begin
    scl_n   = 1'b1;
    sda_n   = 1'b1;
    ready_o = (state == S_IDLE) || (state == S_HOLD);
    case (state_n)
      S_START1, S_STOP1:            sda_n = 1'b0;
      S_START2, S_HOLD, S_DATA_END: begin
        scl_n = 1'b0;
        sda_n = 1'b0;
      end
      S_DATA1, S_DATA4: begin
        scl_n = 1'b0;
        sda_n = tx_n[8];
      end
      S_DATA2, S_DATA3:             sda_n = tx_n[8];
      default: begin
        scl_n = 1'b1;
        sda_n = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_i2c_master.sv
// tb/tb_i2c_master.sv - scoreboard bench for i2c_master with a simple bus slave model
module tb_i2c_master;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] dvsr;
  logic [7:0]  din;
  logic [2:0]  cmd;
  logic        wr;
  wire         scl, sda;
  logic        ready, done_tick, ack;
  logic [7:0]  dout;

  pullup (scl);
  pullup (sda);

  i2c_master dut (
    .clk_i(clk), .rst_i(rst), .dvsr_i(dvsr), .din_i(din), .cmd_i(cmd),
    .wr_i2c_i(wr), .scl_io(scl), .sda_io(sda), .ready_o(ready),
    .done_tick_o(done_tick), .ack_o(ack), .dout_o(dout)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // slave model and bus monitor; slave bit 1 = release, 0 = pull low
  logic [8:0] slv_bits = 9'h1FF;
  int         slv_go = 0, slv_seen = 0, slv_idx = 0;
  logic       slv_drv = 1'b0, slv_active = 1'b0;
  logic       bus_bits_q[$];
  int         rise_q[$], fall_q[$];
  int         start_cnt = 0, stop_cnt = 0, act_cnt = 0;
  logic       p_scl = 1'b1, p_sda = 1'b1;

  assign sda = slv_drv ? 1'b0 : 1'bz;

  always @(negedge clk) begin
    if (scl !== p_scl || sda !== p_sda) act_cnt++;
    if (p_scl && scl && p_sda && !sda) start_cnt++;
    if (p_scl && scl && !p_sda && sda) stop_cnt++;
    if (!p_scl && scl) begin
      bus_bits_q.push_back(sda);
      rise_q.push_back(cyc);
    end
    if (p_scl && !scl) begin
      fall_q.push_back(cyc);
      if (slv_active) begin
        slv_idx++;
        if (slv_idx < 9) slv_drv = ~slv_bits[8-slv_idx];
        else begin
          slv_drv    = 1'b0;
          slv_active = 1'b0;
        end
      end
    end
    p_scl = scl;
    p_sda = sda;
    if (slv_go != slv_seen) begin
      slv_seen   = slv_go;
      slv_idx    = 0;
      slv_active = 1'b1;
      slv_drv    = ~slv_bits[8];
      bus_bits_q.delete();
      rise_q.delete();
      fall_q.delete();
    end
  end

  // scoreboard: expected {dout, ack} pushed at command issue, compared on done_tick
  logic [8:0] exp_q[$];
  logic [8:0] sb_e;
  int         done_cnt = 0;

  always @(negedge clk) begin
    if (done_tick === 1'b1) begin
      done_cnt++;
      if (exp_q.size() == 0) chk("unexpected_done", {31'd0, done_tick}, 32'd0);
      else begin
        sb_e = exp_q.pop_front();
        chk("sb_dout", {24'd0, dout}, {24'd0, sb_e[8:1]});
        chk("sb_ack", {31'd0, ack}, {31'd0, sb_e[0]});
      end
    end
  end

  task automatic strobe(input logic [2:0] c, input logic [7:0] d);
    @(posedge clk); #1;
    cmd = c; din = d; wr = 1'b1;
    @(posedge clk); #1;
    wr = 1'b0;
  endtask

  task automatic wait_ready(output int n);
    n = 1;
    while (ready !== 1'b1 && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    if (ready !== 1'b1) chk("ready_timeout", {31'd0, ready}, 32'd1);
  endtask

  task automatic do_byte(input logic [2:0] c, input logic [7:0] d, input logic [8:0] sbits,
                         input logic [8:0] exp_sb, output int n);
    slv_bits = sbits;
    slv_go++;
    exp_q.push_back(exp_sb);
    strobe(c, d);
    wait_ready(n);
  endtask

  function automatic logic [8:0] bus_word();
    logic [8:0] v = '0;
    foreach (bus_bits_q[i]) v = {v[7:0], bus_bits_q[i]};
    return v;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int n, a0, s0, p0;
    rst = 1'b1; dvsr = 16'd4; din = 8'h00; cmd = 3'b000; wr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", {31'd0, ready}, 32'd1);
    chk("rst_done", {31'd0, done_tick}, 32'd0);
    chk("rst_ack", {31'd0, ack}, 32'd0);
    chk("rst_dout", {24'd0, dout}, 32'd0);
    chk("rst_scl", {31'd0, scl}, 32'd1);
    chk("rst_sda", {31'd0, sda}, 32'd1);
    rst = 1'b0;

    // STOP while idle must be ignored
    a0 = act_cnt;
    strobe(3'b011, 8'h00);
    repeat (20) @(posedge clk);
    #1;
    chk("idle_stop_ready", {31'd0, ready}, 32'd1);
    chk("idle_stop_activity", act_cnt, a0);

    // START, with a WR poked while busy
    strobe(3'b000, 8'h00);
    chk("start_sda_1clk", {31'd0, sda}, 32'd0);
    chk("start_scl_high", {31'd0, scl}, 32'd1);
    chk("busy_ready_low", {31'd0, ready}, 32'd0);
    strobe(3'b001, 8'h00);
    wait_ready(n);
    chk("start_cond_seen", start_cnt, 1);
    a0 = act_cnt;
    repeat (40) @(posedge clk);
    #1;
    chk("busy_wr_dropped_act", act_cnt, a0);
    chk("busy_wr_dropped_done", done_cnt, 0);
    chk("hold_scl_low", {31'd0, scl}, 32'd0);

    // WR A5, slave ACKs
    do_byte(3'b001, 8'hA5, {8'hFF, 1'b0}, {8'hA5, 1'b0}, n);
    chk("wr_ready_latency", n, 37*4+1);
    chk("wr_bit_count", bus_bits_q.size(), 9);
    chk("wr_sda_pattern", {23'd0, bus_word()}, {23'd0, 9'h14A});
    if (rise_q.size() >= 2 && fall_q.size() >= 1) begin
      chk("scl_high_time", fall_q[0] - rise_q[0], 8);
      chk("scl_period", rise_q[1] - rise_q[0], 16);
    end else chk("scl_edges_seen", rise_q.size(), 9);
    chk("wr_done_pulses", done_cnt, 1);

    // WR 5A, no slave, at a faster rate
    dvsr = 16'd2;
    do_byte(3'b001, 8'h5A, 9'h1FF, {8'h5A, 1'b1}, n);
    chk("wr_fast_latency", n, 37*2+1);
    chk("nack_done_pulses", done_cnt, 2);
    dvsr = 16'd4;

    // repeated START
    s0 = start_cnt;
    strobe(3'b100, 8'h00);
    wait_ready(n);
    chk("restart_cond_seen", start_cnt, s0 + 1);
    chk("restart_latency", n, 5*4+1);

    // RD with master NACK, slave returns 3C
    do_byte(3'b010, 8'h01, {8'h3C, 1'b1}, {8'h3C, 1'b1}, n);
    chk("rd_sda_pattern", {23'd0, bus_word()}, {23'd0, 9'h079});

    // STOP
    p0 = stop_cnt;
    strobe(3'b011, 8'h00);
    wait_ready(n);
    chk("stop_latency", n, 4*4+1);
    chk("stop_cond_seen", stop_cnt, p0 + 1);
    chk("idle_scl", {31'd0, scl}, 32'd1);
    chk("idle_sda", {31'd0, sda}, 32'd1);

    // reset in the middle of DATA2
    strobe(3'b000, 8'h00);
    wait_ready(n);
    chk("start_latency", n, 3*4+1);
    slv_bits = 9'h1FF;
    slv_go++;
    strobe(3'b001, 8'h00);
    n = 0;
    while (scl !== 1'b1 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("data2_sda_low", {31'd0, sda}, 32'd0);
    rst = 1'b1;
    #1;
    chk("midrst_scl", {31'd0, scl}, 32'd1);
    chk("midrst_sda", {31'd0, sda}, 32'd1);
    chk("midrst_ready", {31'd0, ready}, 32'd1);
    chk("midrst_dout", {24'd0, dout}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("sb_queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/i2c_master.md
# i2c_master

Byte-oriented I2C bus master controller. Host logic issues START, WRITE, READ, STOP and RESTART commands one at a time through a command/ready handshake. The block generates open-drain SCL/SDA waveforms at a runtime-programmable rate and returns the received byte and the acknowledge bit. It sits between a processor/bus-register front end and the board-level I2C pins, which are pulled up externally or in the bench.

## Interface
- No parameters; bus rate is set at runtime by `dvsr_i`.
- One clock; reset is asynchronous and active-high.
- `clk_i`  in  1  system clock; all logic is on the rising edge.
- `rst_i`  in  1  asynchronous, active-high reset.
- `dvsr_i`  in  16  quarter-SCL-period length in `clk_i` cycles; 0 is treated as 1.
- `din_i`  in  8  write data (WR); for RD, `din_i[0]` is the ack bit the master sends (0 = ACK, 1 = NACK).
- `cmd_i`  in  3  command: 000 START, 001 WR, 010 RD, 011 STOP, 100 RESTART; other codes are ignored.
- `wr_i2c_i`  in  1  one-cycle command strobe; sampled only while `ready_o` = 1.
- `scl_io`  inout  1  open-drain: drives 0 or releases to Z, never drives 1.
- `sda_io`  inout  1  open-drain: same rule as `scl_io`.
- `ready_o`  out  1  high in IDLE and HOLD, meaning a command is accepted.
- `done_tick_o`  out  1  one-cycle pulse when a WR/RD byte (9 bits) completes.
- `ack_o`  out  1  last sampled 9th bit: slave ACK for WR, echo of master bit for RD.
- `dout_o`  out  8  byte sampled during the last WR/RD; MSB first.

## Operation
- SCL and SDA are internal registers and drive the pads only as open-drain. SDA input is sampled from the pad.
- Counter `c` counts clocks. A quarter phase (Q) lasts `dvsr_i` clocks; a half phase (H) lasts 2·`dvsr_i` clocks. `c` clears on every state change.
- FSM states, with SCL/SDA levels (1 = released), duration and transition:
  - IDLE (1/1): `ready_o` = 1. START goes to START1; all other commands are ignored.
  - START1 (1/0), H → START2.
  - START2 (0/0), Q → HOLD.
  - HOLD (0/0): `ready_o` = 1. Latches the command on the strobe:
    - WR loads tx = {`din_i`, 1} and goes to DATA1 with bit = 0.
    - RD loads tx = {8'hFF, `din_i[0]`} and goes to DATA1 with bit = 0.
    - STOP goes to STOP1.
    - START or RESTART goes to RESTART.
  - DATA1 (0/tx[8]), Q → DATA2.
  - DATA2 (1/tx[8]), Q → DATA3. On exit, rx ← {rx[7:0], sda_in}.
  - DATA3 (1/tx[8]), Q → DATA4.
  - DATA4 (0/tx[8]), Q:
    - if bit = 8: pulse `done_tick_o` and go to DATA_END;
    - else shift tx left, increment bit, go to DATA1.
  - DATA_END (0/0), Q → HOLD.
  - RESTART (1/1), H → START1.
  - STOP1 (1/0), H → STOP2.
  - STOP2 (1/1), H → IDLE.
- `dout_o` = rx[8:1] and `ack_o` = rx[0]. Both are registered and update with `done_tick_o`, then hold until the next byte completes.
- `din_i` and `dvsr_i` changes during a transfer are ignored for the current phase. `dvsr_i` is re-read at each phase start.
- No clock stretching and no arbitration. The block ignores SCL read-back.

## Timing
- Reset (async): state = IDLE, SCL/SDA released, `done_tick_o` = 0, `ack_o` = 0, `dout_o` = 0, `ready_o` = 1 (follows IDLE). Reset mid-transfer releases both lines immediately.
- `ready_o` drops the cycle after the accepting strobe. A strobe with `ready_o` = 0 is dropped.
- START latency: SDA falls 1 clock after the strobe. Strobe-to-HOLD is 3·`dvsr_i` + 1 clocks.
- Byte: 36·`dvsr_i` clocks of bit phases, then `done_tick_o`, then Q in DATA_END. `ready_o` reasserts 37·`dvsr_i` + 1 clocks after the strobe.
- STOP: SDA rises (STOP condition) H after SCL is released. IDLE is reached 4·`dvsr_i` + 1 clocks after the strobe.
- SDA changes only while SCL is low, except in START1/STOP2 transitions.

## Test plan
- Reset: assert `rst_i` mid-DATA2 → `scl_io`/`sda_io` read 1 (pull-up) at once, `ready_o` = 1, `dout_o` = 0.
- `dvsr_i` = 4, START then WR `din_i` = 8'hA5, slave ACKs bit 9:
  - SDA pattern 1,0,1,0,0,1,0,1, then released;
  - `done_tick_o` one pulse, `ack_o` = 0, `dout_o` = 8'hA5;
  - SCL high time is 8 clocks, period 16 clocks.
- WR with no slave (SDA floats high) → `ack_o` = 1.
- RD with `din_i` = 1, slave drives 8'h3C → `dout_o` = 8'h3C; master releases SDA on bit 9 so `ack_o` = 1 (NACK).
- START, WR, RESTART, RD, STOP:
  - repeated START seen (SDA falls while SCL is high);
  - STOP: SDA rises while SCL is high;
  - then IDLE with both lines high.
- Handshake: strobe STOP while in IDLE, and WR while busy, are ignored (no bus activity, `ready_o` unchanged).
